// File: rtl/spi_cmd_master.sv
// SPI mode-0 command master: shifts one 48-bit MRAM frame MSB first and returns the
// last 16 MISO bits. Every output is driven straight from a flop.
module spi_cmd_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic        FPGA_clk,
  input  logic        FPGA_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_rws,
  input  logic        cmd_mode_sel,
  input  logic [3:0]  cmd_burst_len,
  input  logic [19:0] cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic        MISO,
  output logic        SCLK,
  output logic        SSEL,
  output logic        MOSI,
  output logic [15:0] rd_data,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [5:0] EDGE_LAST = 6'd48;
  // Rising edges numbered above this one carry the read data.
  localparam logic [5:0] CAP_AFTER = 6'd32;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_div, w_div_nxt;
  logic [5:0]  r_edge, w_edge_nxt;
  logic [47:0] r_frame, w_frame_nxt;
  logic [15:0] r_cap, w_cap_nxt;
  logic [15:0] r_rd_data, w_rd_data_nxt;
  logic        r_sclk, w_sclk_nxt;
  logic        r_ssel, w_ssel_nxt;
  logic        r_mosi, w_mosi_nxt;
  logic        r_done, w_done_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_ready, w_ready_nxt;
  logic        w_div_end;

  // Next-state and next-register decode; every register holds unless its state moves it.
  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = r_div;
    w_edge_nxt    = r_edge;
    w_frame_nxt   = r_frame;
    w_cap_nxt     = r_cap;
    w_rd_data_nxt = r_rd_data;
    w_sclk_nxt    = r_sclk;
    w_ssel_nxt    = r_ssel;
    w_mosi_nxt    = r_mosi;
    w_done_nxt    = 1'b0;
    w_busy_nxt    = r_busy;
    w_ready_nxt   = r_ready;
    w_div_end     = (r_div == DIV_LAST);
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = ST_SETUP;
          w_frame_nxt = {cmd_rws, cmd_mode_sel, cmd_burst_len, 4'b0000, cmd_addr, cmd_data};
          w_mosi_nxt  = cmd_rws[2];
          w_ssel_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_ready_nxt = 1'b0;
          w_div_nxt   = 8'd0;
          w_edge_nxt  = 6'd0;
          w_cap_nxt   = 16'h0000;
        end else begin
          w_ready_nxt = 1'b1;
        end
      end
      ST_SETUP: begin
        if (w_div_end) begin
          w_state_nxt = ST_SHIFT;
          w_div_nxt   = 8'd0;
        end else begin
          w_div_nxt = r_div + 8'd1;
        end
      end
      ST_SHIFT: begin
        if (!w_div_end) begin
          w_div_nxt = r_div + 8'd1;
        end else if (!r_sclk) begin
          w_div_nxt  = 8'd0;
          w_sclk_nxt = 1'b1;
          w_edge_nxt = r_edge + 6'd1;
          if (r_edge >= CAP_AFTER) begin
            w_cap_nxt = {r_cap[14:0], MISO};
          end else begin
            w_cap_nxt = r_cap;
          end
        end else if (r_edge == EDGE_LAST) begin
          w_div_nxt   = 8'd0;
          w_sclk_nxt  = 1'b0;
          w_state_nxt = ST_HOLD;
        end else begin
          // Falling edge: present the next bit while SCLK is low.
          w_div_nxt   = 8'd0;
          w_sclk_nxt  = 1'b0;
          w_frame_nxt = {r_frame[46:0], 1'b0};
          w_mosi_nxt  = r_frame[46];
        end
      end
      ST_HOLD: begin
        if (w_div_end) begin
          w_state_nxt   = ST_GAP;
          w_div_nxt     = 8'd0;
          w_ssel_nxt    = 1'b1;
          w_mosi_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_rd_data_nxt = r_cap;
        end else begin
          w_div_nxt = r_div + 8'd1;
        end
      end
      ST_GAP: begin
        if (r_div == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_div_nxt   = 8'd0;
          w_busy_nxt  = 1'b0;
          w_ready_nxt = 1'b1;
        end else begin
          w_div_nxt = r_div + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_div_nxt   = 8'd0;
        w_edge_nxt  = 6'd0;
        w_sclk_nxt  = 1'b0;
        w_ssel_nxt  = 1'b1;
        w_mosi_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge FPGA_clk or posedge FPGA_rst) begin
    if (FPGA_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters, shift registers and output flops; reset drives the idle bus levels.
  always_ff @(posedge FPGA_clk or posedge FPGA_rst) begin
    if (FPGA_rst) begin
      r_div     <= 8'd0;
      r_edge    <= 6'd0;
      r_frame   <= 48'h0;
      r_cap     <= 16'h0000;
      r_rd_data <= 16'h0000;
      r_sclk    <= 1'b0;
      r_ssel    <= 1'b1;
      r_mosi    <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_div     <= w_div_nxt;
      r_edge    <= w_edge_nxt;
      r_frame   <= w_frame_nxt;
      r_cap     <= w_cap_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_sclk    <= w_sclk_nxt;
      r_ssel    <= w_ssel_nxt;
      r_mosi    <= w_mosi_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= w_busy_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign cmd_ready = r_ready;
  assign SCLK      = r_sclk;
  assign SSEL      = r_ssel;
  assign MOSI      = r_mosi;
  assign rd_data   = r_rd_data;
  assign done      = r_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Self-checking bench for spi_cmd_master: one instance at CLK_DIV=4 and one at CLK_DIV=1,
// driven from shared stimulus and checked against a frame-level model and a mode-0 slave.
module tb_spi_cmd_master;

  localparam int GAP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [2:0]  cmd_rws;
  logic        cmd_mode_sel;
  logic [3:0]  cmd_burst_len;
  logic [19:0] cmd_addr;
  logic [15:0] cmd_data;
  logic        miso;
  logic        sel;

  logic        ready4, sclk4, ssel4, mosi4, done4, busy4;
  logic        ready1, sclk1, ssel1, mosi1, done1, busy1;
  logic [15:0] rd4, rd1;
  logic        ready_m, sclk_m, ssel_m, mosi_m, done_m, busy_m;
  logic [15:0] rd_m;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          rises    = 0;
  int          viol     = 0;
  logic [47:0] mon_bits = 48'h0;
  logic [47:0] miso_word = 48'h0;
  logic [5:0]  idx = 6'd0;
  logic        sclk_prev = 1'b0;
  logic        mosi_prev = 1'b0;
  logic        ssel_prev = 1'b1;
  logic [15:0] prev_rd;

  always #5 clk = ~clk;

  spi_cmd_master #(.CLK_DIV(4), .GAP_CYCLES(GAP)) u_dut4 (
    .FPGA_clk(clk), .FPGA_rst(rst), .cmd_valid(cmd_valid & ~sel), .cmd_ready(ready4),
    .cmd_rws(cmd_rws), .cmd_mode_sel(cmd_mode_sel), .cmd_burst_len(cmd_burst_len),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .MISO(miso), .SCLK(sclk4), .SSEL(ssel4),
    .MOSI(mosi4), .rd_data(rd4), .done(done4), .busy(busy4));

  spi_cmd_master #(.CLK_DIV(1), .GAP_CYCLES(GAP)) u_dut1 (
    .FPGA_clk(clk), .FPGA_rst(rst), .cmd_valid(cmd_valid & sel), .cmd_ready(ready1),
    .cmd_rws(cmd_rws), .cmd_mode_sel(cmd_mode_sel), .cmd_burst_len(cmd_burst_len),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .MISO(miso), .SCLK(sclk1), .SSEL(ssel1),
    .MOSI(mosi1), .rd_data(rd1), .done(done1), .busy(busy1));

  assign ready_m = sel ? ready1 : ready4;
  assign sclk_m  = sel ? sclk1  : sclk4;
  assign ssel_m  = sel ? ssel1  : ssel4;
  assign mosi_m  = sel ? mosi1  : mosi4;
  assign done_m  = sel ? done1  : done4;
  assign busy_m  = sel ? busy1  : busy4;
  assign rd_m    = sel ? rd1    : rd4;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Mode-0 slave and bus monitor: MISO moves only on SCLK falls, MOSI captured on rises.
  always @(negedge clk) begin
    if (ssel_prev && !ssel_m) begin
      rises    = 0;
      mon_bits = 48'h0;
      idx      = 6'd47;
      miso     = miso_word[idx];
    end
    if (!sclk_prev && sclk_m) begin
      mon_bits = {mon_bits[46:0], mosi_m};
      rises++;
    end
    if (sclk_prev && !sclk_m && idx > 6'd0) begin
      idx  = idx - 6'd1;
      miso = miso_word[idx];
    end
    if (sclk_prev && sclk_m && (mosi_m !== mosi_prev)) viol++;
    sclk_prev = sclk_m;
    mosi_prev = mosi_m;
    ssel_prev = ssel_m;
  end

  task automatic run_cmd(input logic [2:0] rws, input logic mode, input logic [3:0] bl,
                         input logic [19:0] addr, input logic [15:0] data,
                         input logic [47:0] word, input bit keep);
    logic [47:0] exp_frame;
    int div, lat, cnt, gap, bad_hs, bad_hold, bad_gap;
    div       = sel ? 1 : 4;
    lat       = 2 * div * 48 + 2 * div + 1;
    exp_frame = {rws, mode, bl, 4'b0000, addr, data};
    miso_word = word;
    viol      = 0;
    chk("ready_before_cmd", 64'(ready_m), 64'(1'b1));
    cmd_rws = rws; cmd_mode_sel = mode; cmd_burst_len = bl;
    cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    @(posedge clk);
    cnt = 0; bad_hs = 0; bad_hold = 0;
    do begin
      @(negedge clk);
      if (!keep) cmd_valid = 1'b0;
      cnt++;
      if (cnt == 2) begin
        cmd_addr = 20'($urandom);
        cmd_data = 16'($urandom);
      end
      if (ready_m || !busy_m) bad_hs++;
      if (!done_m && rd_m !== prev_rd) bad_hold++;
    end while (!done_m && cnt < lat + 50);
    chk("done_latency", 64'(cnt), 64'(lat));
    chk("rd_data", 64'(rd_m), 64'(word[15:0]));
    chk("sclk_rises", 64'(rises), 64'(48));
    chk("mosi_frame", 64'(mon_bits), 64'(exp_frame));
    chk("mosi_change_while_sclk_high", 64'(viol), 64'(0));
    chk("ready_busy_in_frame", 64'(bad_hs), 64'(0));
    chk("rd_hold_before_done", 64'(bad_hold), 64'(0));
    prev_rd = word[15:0];
    gap = 1;
    bad_gap = (ssel_m !== 1'b1) ? 1 : 0;
    while (!ready_m && gap < GAP + 50) begin
      @(negedge clk);
      if (done_m) bad_gap++;
      if (rd_m !== prev_rd) bad_gap++;
      if (!ready_m) begin
        gap++;
        if (ssel_m !== 1'b1 || !busy_m) bad_gap++;
      end
    end
    chk("gap_len", 64'(gap), 64'(GAP));
    chk("gap_ssel_done_rd", 64'(bad_gap), 64'(0));
    chk("busy_low_at_ready", 64'(busy_m), 64'(1'b0));
  endtask

  initial begin
    int wt;
    rst = 1'b1; cmd_valid = 1'b0; cmd_rws = 3'd0; cmd_mode_sel = 1'b0;
    cmd_burst_len = 4'd0; cmd_addr = 20'd0; cmd_data = 16'd0; miso = 1'b0;
    sel = 1'b0; prev_rd = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_ssel", 64'(ssel_m), 64'(1'b1));
    chk("rst_sclk", 64'(sclk_m), 64'(1'b0));
    chk("rst_mosi", 64'(mosi_m), 64'(1'b0));
    chk("rst_done_busy", 64'({done_m, busy_m}), 64'(2'b00));
    chk("rst_rd_data", 64'(rd_m), 64'(16'h0000));
    rst = 1'b0;
    @(negedge clk);

    run_cmd(3'b001, 1'b0, 4'h0, 20'hABCDE, 16'h1234, {16'($urandom), 16'($urandom), 16'hBEEF}, 1'b0);
    for (int i = 0; i < 3; i++)
      run_cmd(3'($urandom), 1'($urandom), 4'($urandom), 20'($urandom), 16'($urandom),
              {16'($urandom), 32'($urandom)}, 1'b0);

    // Back-to-back with cmd_valid held high across both frames.
    run_cmd(3'($urandom), 1'b0, 4'($urandom), 20'($urandom), 16'($urandom),
            {16'($urandom), 32'($urandom)}, 1'b1);
    run_cmd(3'($urandom), 1'b1, 4'($urandom), 20'($urandom), 16'($urandom),
            {16'($urandom), 32'($urandom)}, 1'b0);

    // Abort a frame with reset at the 20th SCLK rise.
    miso_word = {16'($urandom), 32'($urandom)};
    cmd_rws = 3'($urandom); cmd_addr = 20'($urandom); cmd_data = 16'($urandom);
    rises = 0;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wt = 0;
    while (rises < 20 && wt < 2000) begin
      @(negedge clk);
      wt++;
    end
    chk("abort_at_edge20", 64'(rises), 64'(20));
    #2 rst = 1'b1;
    #1;
    chk("abort_ssel_async", 64'(ssel_m), 64'(1'b1));
    chk("abort_sclk_async", 64'(sclk_m), 64'(1'b0));
    chk("abort_done_busy", 64'({done_m, busy_m}), 64'(2'b00));
    chk("abort_rd_cleared", 64'(rd_m), 64'(16'h0000));
    @(negedge clk);
    rst = 1'b0;
    prev_rd = 16'h0000;
    @(negedge clk);
    chk("ready_after_abort", 64'(ready_m), 64'(1'b1));
    chk("no_done_after_abort", 64'(done_m), 64'(1'b0));
    run_cmd(3'($urandom), 1'($urandom), 4'($urandom), 20'($urandom), 16'($urandom),
            {16'($urandom), 32'($urandom)}, 1'b0);

    // Fastest divider: SCLK at half the block clock.
    sel = 1'b1;
    prev_rd = 16'h0000;
    @(negedge clk);
    run_cmd(3'($urandom), 1'b1, 4'hF, 20'($urandom), 16'($urandom),
            {16'($urandom), 32'($urandom)}, 1'b0);
    for (int i = 0; i < 3; i++)
      run_cmd(3'($urandom), 1'($urandom), 4'($urandom), 20'($urandom), 16'($urandom),
              {16'($urandom), 32'($urandom)}, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
